// File: rtl/uart_gen2.sv
// Parametrised full-duplex UART with TX/RX FIFOs and sticky receive error flags.
// Frame layout (data width, parity, stop bits) and bit period are fixed per instance.
module uart_gen2 #(
   parameter int CLKS_PER_BIT = 32,
   parameter int DATA_BITS    = 8,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_AW      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ser_rxd,
   output logic               ser_txd,
   input  logic               tx_wr,
   input  logic [7:0]         tx_din,
   output logic               tx_full,
   output logic               tx_busy,
   input  logic               rx_rd,
   output logic [7:0]         rx_dout,
   output logic               rx_rdy,
   output logic [FIFO_AW:0]   rx_level,
   input  logic               err_clr,
   output logic               frame_err,
   output logic               parity_err,
   output logic               overrun_err
);

   localparam int CW = 16;
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [CW-1:0]    BIT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]    SAMPLE_AT  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       DATA_LAST  = 3'(DATA_BITS - 1);
   localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
   localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] txMem_q [DEPTH];
   logic [FIFO_AW-1:0]   txWrPtr_q, txWrPtr_d, txRdPtr_q, txRdPtr_d;
   logic [FIFO_AW:0]     txCount_q, txCount_d;
   logic                 txPush, txPop, txNotEmpty;
   logic [DATA_BITS-1:0] txHeadData;
   logic                 txHeadPar;

   assign txPush     = tx_wr && (txCount_q != FULL_LEVEL);
   assign txNotEmpty = (txCount_q != '0);
   assign txHeadData = txMem_q[txRdPtr_q];
   assign txHeadPar  = (^txHeadData) ^ PARITY_ODD;

   always_ff @(posedge clk) begin
      if (txPush) txMem_q[txWrPtr_q] <= tx_din[DATA_BITS-1:0];
   end

   always_comb begin
      txWrPtr_d = txWrPtr_q + FIFO_AW'(txPush);
      txRdPtr_d = txRdPtr_q + FIFO_AW'(txPop);
      txCount_d = txCount_q;
      case ({txPush, txPop})
         2'b10:   txCount_d = txCount_q + 1'b1;
         2'b01:   txCount_d = txCount_q - 1'b1;
         default: txCount_d = txCount_q;
      endcase
   end

   // ---------------- TX FSM ----------------
   state_e               txState_q, txState_d;
   logic [CW-1:0]        txCnt_q, txCnt_d;
   logic [2:0]           txBit_q, txBit_d;
   logic                 txStop_q, txStop_d;
   logic [DATA_BITS-1:0] txShift_q, txShift_d;
   logic                 txPar_q, txPar_d;
   logic                 txd_q, txd_d;
   logic                 txBitEnd;

   assign txBitEnd = (txCnt_q == BIT_LAST);

   always_comb begin
      txState_d = txState_q;
      txCnt_d   = txCnt_q;
      txBit_d   = txBit_q;
      txStop_d  = txStop_q;
      txShift_d = txShift_q;
      txPar_d   = txPar_q;
      txPop     = 1'b0;
      if (txState_q != S_IDLE) txCnt_d = txBitEnd ? '0 : txCnt_q + CW'(1);
      case (txState_q)
         S_IDLE: begin
            if (txNotEmpty) begin
               txPop     = 1'b1;
               txShift_d = txHeadData;
               txPar_d   = txHeadPar;
               txCnt_d   = '0;
               txState_d = S_START;
            end
         end
         S_START: begin
            if (txBitEnd) begin
               txBit_d   = '0;
               txState_d = S_DATA;
            end
         end
         S_DATA: begin
            if (txBitEnd) begin
               txShift_d = txShift_q >> 1;
               txBit_d   = txBit_q + 3'd1;
               txStop_d  = 1'b0;
               if (txBit_q == DATA_LAST) txState_d = PARITY_EN ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (txBitEnd) begin
               txStop_d  = 1'b0;
               txState_d = S_STOP;
            end
         end
         S_STOP: begin
            if (txBitEnd) begin
               txStop_d = txStop_q + 1'b1;
               // Chain straight into the next start bit so back-to-back frames have no gap
               if (txStop_q == STOP_LAST) begin
                  if (txNotEmpty) begin
                     txPop     = 1'b1;
                     txShift_d = txHeadData;
                     txPar_d   = txHeadPar;
                     txState_d = S_START;
                  end else begin
                     txState_d = S_IDLE;
                  end
               end
            end
         end
         default: txState_d = S_IDLE;
      endcase
   end

   always_comb begin
      txd_d = 1'b1;
      case (txState_q)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = txShift_q[0];
         S_PARITY: txd_d = txPar_q;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txWrPtr_q <= '0;
         txRdPtr_q <= '0;
         txCount_q <= '0;
         txState_q <= S_IDLE;
         txCnt_q   <= '0;
         txBit_q   <= '0;
         txStop_q  <= 1'b0;
         txShift_q <= '0;
         txPar_q   <= 1'b0;
         txd_q     <= 1'b1;
      end else begin
         txWrPtr_q <= txWrPtr_d;
         txRdPtr_q <= txRdPtr_d;
         txCount_q <= txCount_d;
         txState_q <= txState_d;
         txCnt_q   <= txCnt_d;
         txBit_q   <= txBit_d;
         txStop_q  <= txStop_d;
         txShift_q <= txShift_d;
         txPar_q   <= txPar_d;
         txd_q     <= txd_d;
      end
   end

   assign ser_txd = txd_q;
   assign tx_full = (txCount_q == FULL_LEVEL);
   assign tx_busy = txNotEmpty || (txState_q != S_IDLE);

   // ---------------- RX synchroniser and FSM ----------------
   logic                 rxSync1_q, rxSync2_q, rxPrev_q;
   state_e               rxState_q, rxState_d;
   logic [CW-1:0]        rxCnt_q, rxCnt_d;
   logic [2:0]           rxBit_q, rxBit_d;
   logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
   logic                 rxParBit_q, rxParBit_d;
   logic                 rxSample, rxBitEnd;
   logic                 rxPush, rxPop;
   logic                 frameSet, paritySet, overrunSet;
   logic [FIFO_AW:0]     rxCount_q, rxCount_d;

   assign rxSample = (rxCnt_q == SAMPLE_AT);
   assign rxBitEnd = (rxCnt_q == BIT_LAST);
   assign rxPop    = rx_rd && (rxCount_q != '0);

   always_comb begin
      rxState_d  = rxState_q;
      rxCnt_d    = rxCnt_q;
      rxBit_d    = rxBit_q;
      rxShift_d  = rxShift_q;
      rxParBit_d = rxParBit_q;
      rxPush     = 1'b0;
      frameSet   = 1'b0;
      paritySet  = 1'b0;
      overrunSet = 1'b0;
      if (rxState_q != S_IDLE) rxCnt_d = rxBitEnd ? '0 : rxCnt_q + CW'(1);
      case (rxState_q)
         S_IDLE: begin
            // The cycle the falling edge is seen counts as count 0 of the start bit
            if (rxPrev_q && !rxSync2_q) begin
               rxCnt_d   = CW'(1);
               rxState_d = S_START;
            end
         end
         S_START: begin
            if (rxSample && rxSync2_q) begin
               rxState_d = S_IDLE;
            end else if (rxBitEnd) begin
               rxBit_d   = '0;
               rxState_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rxSample) rxShift_d = {rxSync2_q, rxShift_q[DATA_BITS-1:1]};
            if (rxBitEnd) begin
               rxBit_d = rxBit_q + 3'd1;
               if (rxBit_q == DATA_LAST) rxState_d = PARITY_EN ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (rxSample) rxParBit_d = rxSync2_q;
            if (rxBitEnd) rxState_d = S_STOP;
         end
         S_STOP: begin
            if (rxSample) begin
               rxState_d = S_IDLE;
               if (!rxSync2_q) begin
                  frameSet = 1'b1;
               end else begin
                  if (PARITY_EN && (rxParBit_q != ((^rxShift_q) ^ PARITY_ODD))) paritySet = 1'b1;
                  if ((rxCount_q != FULL_LEVEL) || rxPop) rxPush = 1'b1;
                  else overrunSet = 1'b1;
               end
            end
         end
         default: rxState_d = S_IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   logic [DATA_BITS-1:0] rxMem_q [DEPTH];
   logic [FIFO_AW-1:0]   rxWrPtr_q, rxWrPtr_d, rxRdPtr_q, rxRdPtr_d;
   logic [7:0]           rxDout_q, rxDout_d;
   logic                 frameErr_q, parityErr_q, overrunErr_q;

   always_ff @(posedge clk) begin
      if (rxPush) rxMem_q[rxWrPtr_q] <= rxShift_q;
   end

   always_comb begin
      rxWrPtr_d = rxWrPtr_q + FIFO_AW'(rxPush);
      rxRdPtr_d = rxRdPtr_q + FIFO_AW'(rxPop);
      rxCount_d = rxCount_q;
      case ({rxPush, rxPop})
         2'b10:   rxCount_d = rxCount_q + 1'b1;
         2'b01:   rxCount_d = rxCount_q - 1'b1;
         default: rxCount_d = rxCount_q;
      endcase
      // Show-ahead head register; bypass the byte being written when it becomes the head
      if (rxCount_d == '0) rxDout_d = '0;
      else if (rxPush && (rxWrPtr_q == rxRdPtr_d)) rxDout_d = 8'(rxShift_q);
      else rxDout_d = 8'(rxMem_q[rxRdPtr_d]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxSync1_q    <= 1'b1;
         rxSync2_q    <= 1'b1;
         rxPrev_q     <= 1'b1;
         rxState_q    <= S_IDLE;
         rxCnt_q      <= '0;
         rxBit_q      <= '0;
         rxShift_q    <= '0;
         rxParBit_q   <= 1'b0;
         rxWrPtr_q    <= '0;
         rxRdPtr_q    <= '0;
         rxCount_q    <= '0;
         rxDout_q     <= '0;
         frameErr_q   <= 1'b0;
         parityErr_q  <= 1'b0;
         overrunErr_q <= 1'b0;
      end else begin
         rxSync1_q    <= ser_rxd;
         rxSync2_q    <= rxSync1_q;
         rxPrev_q     <= rxSync2_q;
         rxState_q    <= rxState_d;
         rxCnt_q      <= rxCnt_d;
         rxBit_q      <= rxBit_d;
         rxShift_q    <= rxShift_d;
         rxParBit_q   <= rxParBit_d;
         rxWrPtr_q    <= rxWrPtr_d;
         rxRdPtr_q    <= rxRdPtr_d;
         rxCount_q    <= rxCount_d;
         rxDout_q     <= rxDout_d;
         frameErr_q   <= frameSet   | (frameErr_q   & ~err_clr);
         parityErr_q  <= paritySet  | (parityErr_q  & ~err_clr);
         overrunErr_q <= overrunSet | (overrunErr_q & ~err_clr);
      end
   end

   assign rx_dout     = rxDout_q;
   assign rx_rdy      = (rxCount_q != '0);
   assign rx_level    = rxCount_q;
   assign frame_err   = frameErr_q;
   assign parity_err  = parityErr_q;
   assign overrun_err = overrunErr_q;

endmodule

// File: tb/tb_uart_gen2.sv
// Directed bench for uart_gen2: 8N1 instance (A), 8E1 loopback instance (B), 8O1 receive instance (C).
// Inputs change #1 after a rising edge; outputs are read in that same settled window.
module tb_uart_gen2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   errors = 0;
   int   checks = 0;

   logic       rxdA, txdA, txWrA, txFullA, txBusyA, rxRdA, rxRdyA, errClrA;
   logic       frameErrA, parErrA, ovrErrA;
   logic [7:0] txDinA, rxDoutA;
   logic [4:0] rxLevelA;

   logic       txdB, txWrB, txFullB, txBusyB, rxRdB, rxRdyB, errClrB;
   logic       frameErrB, parErrB, ovrErrB;
   logic [7:0] txDinB, rxDoutB;
   logic [4:0] rxLevelB;

   logic       rxdC, txdC, txWrC, txFullC, txBusyC, rxRdC, rxRdyC, errClrC;
   logic       frameErrC, parErrC, ovrErrC;
   logic [7:0] txDinC, rxDoutC;
   logic [4:0] rxLevelC;

   uart_gen2 #(.CLKS_PER_BIT(32), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
               .STOP_BITS(1), .FIFO_AW(4)) u_dutA (
      .clk(clk), .rst(rst), .ser_rxd(rxdA), .ser_txd(txdA), .tx_wr(txWrA), .tx_din(txDinA),
      .tx_full(txFullA), .tx_busy(txBusyA), .rx_rd(rxRdA), .rx_dout(rxDoutA), .rx_rdy(rxRdyA),
      .rx_level(rxLevelA), .err_clr(errClrA), .frame_err(frameErrA), .parity_err(parErrA),
      .overrun_err(ovrErrA));

   uart_gen2 #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
               .STOP_BITS(1), .FIFO_AW(4)) u_dutB (
      .clk(clk), .rst(rst), .ser_rxd(txdB), .ser_txd(txdB), .tx_wr(txWrB), .tx_din(txDinB),
      .tx_full(txFullB), .tx_busy(txBusyB), .rx_rd(rxRdB), .rx_dout(rxDoutB), .rx_rdy(rxRdyB),
      .rx_level(rxLevelB), .err_clr(errClrB), .frame_err(frameErrB), .parity_err(parErrB),
      .overrun_err(ovrErrB));

   uart_gen2 #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1),
               .STOP_BITS(1), .FIFO_AW(4)) u_dutC (
      .clk(clk), .rst(rst), .ser_rxd(rxdC), .ser_txd(txdC), .tx_wr(txWrC), .tx_din(txDinC),
      .tx_full(txFullC), .tx_busy(txBusyC), .rx_rd(rxRdC), .rx_dout(rxDoutC), .rx_rdy(rxRdyC),
      .rx_level(rxLevelC), .err_clr(errClrC), .frame_err(frameErrC), .parity_err(parErrC),
      .overrun_err(ovrErrC));

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_line(input int sel, input logic v);
      if (sel == 0) rxdA = v;
      else rxdC = v;
   endtask

   // Serial frame into instance A (sel 0, 32 clk/bit) or C (sel 1, 8 clk/bit)
   task automatic send_serial(input int sel, input logic [7:0] data, input logic withPar,
                              input logic parBit, input logic stopBit);
      int cpb;
      cpb = (sel == 0) ? 32 : 8;
      drive_line(sel, 1'b0);
      tick(cpb);
      for (int i = 0; i < 8; i++) begin
         drive_line(sel, data[i]);
         tick(cpb);
      end
      if (withPar) begin
         drive_line(sel, parBit);
         tick(cpb);
      end
      drive_line(sel, stopBit);
      tick(cpb);
      drive_line(sel, 1'b1);
   endtask

   task automatic test_reset();
      tick(2);
      checks++; if (txdA !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd_during: got %b want 1", txdA); end
      rst = 1'b1;
      tick(3);
      checks++; if ({txdA, txdB, txdC} !== 3'b111) begin errors++; $display("[TB] FAIL reset_txd: got %b want 111", {txdA, txdB, txdC}); end
      checks++; if ({txBusyA, txBusyB, txBusyC, txFullA, txFullB, txFullC} !== 6'b0) begin errors++; $display("[TB] FAIL reset_tx_status: got %b want 000000", {txBusyA, txBusyB, txBusyC, txFullA, txFullB, txFullC}); end
      checks++; if ({rxRdyA, rxRdyB, rxRdyC} !== 3'b0) begin errors++; $display("[TB] FAIL reset_rx_rdy: got %b want 000", {rxRdyA, rxRdyB, rxRdyC}); end
      checks++; if ({rxLevelA, rxLevelB, rxLevelC} !== 15'd0) begin errors++; $display("[TB] FAIL reset_rx_level: got %h want 0", {rxLevelA, rxLevelB, rxLevelC}); end
      checks++; if ({rxDoutA, rxDoutB, rxDoutC} !== 24'h0) begin errors++; $display("[TB] FAIL reset_rx_dout: got %h want 0", {rxDoutA, rxDoutB, rxDoutC}); end
      checks++; if ({frameErrA, parErrA, ovrErrA, frameErrB, parErrB, ovrErrB, frameErrC, parErrC, ovrErrC} !== 9'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b want 0", {frameErrA, parErrA, ovrErrA, frameErrB, parErrB, ovrErrB, frameErrC, parErrC, ovrErrC}); end
   endtask

   task automatic test_tx_frame();
      logic [7:0] b;
      b = 8'hA5;
      txDinA = b;
      txWrA  = 1'b1;
      tick(1);
      txWrA = 1'b0;
      tick(1);
      checks++; if (txdA !== 1'b1) begin errors++; $display("[TB] FAIL tx_n1_idle: got %b want 1", txdA); end
      tick(1);
      checks++; if (txdA !== 1'b0) begin errors++; $display("[TB] FAIL tx_n2_start: got %b want 0", txdA); end
      tick(31);
      checks++; if (txdA !== 1'b0) begin errors++; $display("[TB] FAIL tx_start_last: got %b want 0", txdA); end
      tick(1);
      checks++; if (txdA !== b[0]) begin errors++; $display("[TB] FAIL tx_data0: got %b want %b", txdA, b[0]); end
      for (int k = 1; k < 8; k++) begin
         tick(32);
         checks++; if (txdA !== b[k]) begin errors++; $display("[TB] FAIL tx_data%0d: got %b want %b", k, txdA, b[k]); end
      end
      tick(32);
      checks++; if (txdA !== 1'b1) begin errors++; $display("[TB] FAIL tx_stop: got %b want 1", txdA); end
      tick(30);
      checks++; if (txBusyA !== 1'b1) begin errors++; $display("[TB] FAIL tx_busy_n320: got %b want 1", txBusyA); end
      tick(1);
      checks++; if (txBusyA !== 1'b0) begin errors++; $display("[TB] FAIL tx_busy_n321: got %b want 0", txBusyA); end
      checks++; if (txdA !== 1'b1) begin errors++; $display("[TB] FAIL tx_idle_after: got %b want 1", txdA); end
   endtask

   task automatic test_frame_error();
      send_serial(0, 8'h55, 1'b0, 1'b0, 1'b0);
      tick(4);
      checks++; if (frameErrA !== 1'b1) begin errors++; $display("[TB] FAIL ferr_set: got %b want 1", frameErrA); end
      checks++; if (rxLevelA !== 5'd0) begin errors++; $display("[TB] FAIL ferr_level: got %0d want 0", rxLevelA); end
      errClrA = 1'b1;
      tick(1);
      errClrA = 1'b0;
      checks++; if (frameErrA !== 1'b0) begin errors++; $display("[TB] FAIL ferr_clear: got %b want 0", frameErrA); end
      rxdA = 1'b0;
      tick(10);
      rxdA = 1'b1;
      tick(64);
      checks++; if ({rxLevelA, frameErrA, parErrA, ovrErrA} !== 8'd0) begin errors++; $display("[TB] FAIL glitch_reject: got %b want 0", {rxLevelA, frameErrA, parErrA, ovrErrA}); end
      send_serial(0, 8'h96, 1'b0, 1'b0, 1'b1);
      tick(4);
      checks++; if (rxLevelA !== 5'd1) begin errors++; $display("[TB] FAIL rx_good_level: got %0d want 1", rxLevelA); end
      checks++; if (rxDoutA !== 8'h96) begin errors++; $display("[TB] FAIL rx_good_data: got %h want 96", rxDoutA); end
      rxRdA = 1'b1;
      tick(1);
      rxRdA = 1'b0;
      checks++; if ({rxLevelA, rxRdyA} !== 6'd0) begin errors++; $display("[TB] FAIL rx_pop_empty: got %b want 0", {rxLevelA, rxRdyA}); end
   endtask

   task automatic test_parity_error();
      send_serial(1, 8'h3C, 1'b1, 1'b0, 1'b1);
      tick(4);
      checks++; if (rxDoutC !== 8'h3C) begin errors++; $display("[TB] FAIL perr_data: got %h want 3c", rxDoutC); end
      checks++; if ({rxRdyC, parErrC, frameErrC} !== 3'b110) begin errors++; $display("[TB] FAIL perr_flags: got %b want 110", {rxRdyC, parErrC, frameErrC}); end
      errClrC = 1'b1;
      rxRdC   = 1'b1;
      tick(1);
      errClrC = 1'b0;
      rxRdC   = 1'b0;
      checks++; if ({parErrC, rxLevelC} !== 6'd0) begin errors++; $display("[TB] FAIL perr_clear: got %b want 0", {parErrC, rxLevelC}); end
      send_serial(1, 8'h3C, 1'b1, 1'b1, 1'b1);
      send_serial(1, 8'h07, 1'b1, 1'b0, 1'b1);
      tick(4);
      checks++; if ({rxLevelC, parErrC} !== 6'b000100) begin errors++; $display("[TB] FAIL podd_good: got %b want 000100", {rxLevelC, parErrC}); end
      checks++; if (rxDoutC !== 8'h3C) begin errors++; $display("[TB] FAIL podd_head: got %h want 3c", rxDoutC); end
      rxRdC = 1'b1;
      tick(1);
      checks++; if (rxDoutC !== 8'h07) begin errors++; $display("[TB] FAIL podd_second: got %h want 07", rxDoutC); end
      tick(1);
      rxRdC = 1'b0;
      checks++; if (rxLevelC !== 5'd0) begin errors++; $display("[TB] FAIL podd_drain: got %0d want 0", rxLevelC); end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 17; i++) send_serial(0, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
      tick(4);
      checks++; if (rxLevelA !== 5'd16) begin errors++; $display("[TB] FAIL ovr_level: got %0d want 16", rxLevelA); end
      checks++; if ({ovrErrA, frameErrA} !== 2'b10) begin errors++; $display("[TB] FAIL ovr_flag: got %b want 10", {ovrErrA, frameErrA}); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (rxDoutA !== 8'h20 + 8'(i)) begin errors++; $display("[TB] FAIL ovr_order%0d: got %h want %h", i, rxDoutA, 8'h20 + 8'(i)); end
         rxRdA = 1'b1;
         tick(1);
         rxRdA = 1'b0;
      end
      checks++; if (rxLevelA !== 5'd0) begin errors++; $display("[TB] FAIL ovr_drained: got %0d want 0", rxLevelA); end
      errClrA = 1'b1;
      tick(1);
      errClrA = 1'b0;
      for (int i = 0; i < 16; i++) send_serial(0, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
      tick(2);
      checks++; if ({rxLevelA, ovrErrA} !== 6'b100000) begin errors++; $display("[TB] FAIL ovr_refill: got %b want 100000", {rxLevelA, ovrErrA}); end
      // Stop sample of this frame lands on edge 306 after the start bit is driven
      fork
         send_serial(0, 8'h50, 1'b0, 1'b0, 1'b1);
         begin
            tick(305);
            rxRdA = 1'b1;
            tick(1);
            rxRdA = 1'b0;
         end
      join
      tick(4);
      checks++; if ({rxLevelA, ovrErrA} !== 6'b100000) begin errors++; $display("[TB] FAIL ovr_samecycle: got %b want 100000", {rxLevelA, ovrErrA}); end
      for (int j = 0; j < 16; j++) begin
         checks++; if (rxDoutA !== ((j < 15) ? 8'h41 + 8'(j) : 8'h50)) begin errors++; $display("[TB] FAIL ovr_rd%0d: got %h", j, rxDoutA); end
         rxRdA = 1'b1;
         tick(1);
         rxRdA = 1'b0;
      end
   endtask

   task automatic test_loopback();
      int nextTx;
      int nextRx;
      int cyc;
      nextTx = 0;
      nextRx = 0;
      cyc    = 0;
      while (nextRx < 256 && cyc < 40000) begin
         txWrB = 1'b0;
         rxRdB = 1'b0;
         if (nextTx < 256 && !txFullB) begin
            txDinB = 8'(nextTx);
            txWrB  = 1'b1;
            nextTx++;
         end
         if (rxRdyB) begin
            checks++; if (rxDoutB !== 8'(nextRx)) begin errors++; $display("[TB] FAIL loop_byte%0d: got %h want %h", nextRx, rxDoutB, 8'(nextRx)); end
            rxRdB = 1'b1;
            nextRx++;
         end
         tick(1);
         cyc++;
      end
      txWrB = 1'b0;
      rxRdB = 1'b0;
      checks++; if (nextRx != 256) begin errors++; $display("[TB] FAIL loop_timeout: got %0d bytes want 256", nextRx); end
      checks++; if ({frameErrB, parErrB, ovrErrB} !== 3'b0) begin errors++; $display("[TB] FAIL loop_flags: got %b want 000", {frameErrB, parErrB, ovrErrB}); end
   endtask

   task automatic test_reset_mid_frame();
      txDinA = 8'h00;
      txWrA  = 1'b1;
      tick(2);
      txWrA = 1'b0;
      tick(100);
      checks++; if ({txdA, txBusyA} !== 2'b01) begin errors++; $display("[TB] FAIL mid_frame_pre: got %b want 01", {txdA, txBusyA}); end
      rst = 1'b0;
      #1;
      checks++; if ({txdA, txBusyA} !== 2'b10) begin errors++; $display("[TB] FAIL rst_async: got %b want 10", {txdA, txBusyA}); end
      tick(2);
      rst = 1'b1;
      tick(3);
      checks++; if ({txdA, txBusyA, txFullA, rxLevelA} !== 8'b10000000) begin errors++; $display("[TB] FAIL rst_release: got %b want 10000000", {txdA, txBusyA, txFullA, rxLevelA}); end
      txDinA = 8'hFF;
      txWrA  = 1'b1;
      tick(1);
      txWrA = 1'b0;
      tick(2);
      checks++; if (txdA !== 1'b0) begin errors++; $display("[TB] FAIL rst_restart: got %b want 0", txdA); end
      tick(330);
   endtask

   initial begin
      rst     = 1'b0;
      rxdA    = 1'b1; txWrA = 1'b0; txDinA = 8'h00; rxRdA = 1'b0; errClrA = 1'b0;
      txWrB   = 1'b0; txDinB = 8'h00; rxRdB = 1'b0; errClrB = 1'b0;
      rxdC    = 1'b1; txWrC = 1'b0; txDinC = 8'h00; rxRdC = 1'b0; errClrC = 1'b0;
      test_reset();
      test_tx_frame();
      test_frame_error();
      test_parity_error();
      test_overrun();
      test_loopback();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
